// File: rtl/mpc_seq.sv
// mpc_seq: microprogram sequencer for the multi-cycle CPU.
// Steps a 6-bit mpc through microcode and decodes AU controls.
module mpc_seq #(
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  entry,
    output logic [5:0]  uaddr,
    input  logic [15:0] uword,
    input  logic        gf,
    output logic        au_en,
    output logic [3:0]  ac,
    output logic        ld_a,
    output logic        ld_b,
    output logic        ld_r,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        SEQ_NEXT = 2'b00,
        SEQ_JUMP = 2'b01,
        SEQ_BRGF = 2'b10,
        SEQ_END  = 2'b11
    } seq_op_t;

    localparam logic [7:0] LP_LAST   = 8'(MAX_STEPS - 1);
    localparam logic [3:0] LP_AC_CMP = 4'b1001;

    state_t     r_state;
    logic [5:0] r_mpc;
    logic [7:0] r_step;
    logic       r_gfq;
    logic       r_done;
    logic       r_err;

    seq_op_t    w_op;
    logic [5:0] w_target;
    logic [5:0] w_inc;
    logic [5:0] w_next;
    logic       w_run;
    logic       w_cmp;
    logic       w_trip;

    assign w_op     = seq_op_t'(uword[15:14]);
    assign w_target = uword[13:8];
    assign w_inc    = r_mpc + 6'd1;
    assign w_run    = (r_state == S_RUN);
    assign w_cmp    = uword[3] && (uword[7:4] == LP_AC_CMP);
    assign w_trip   = (r_step == LP_LAST);

    // Next mpc for non-END microwords; branches see only the captured flag
    always_comb begin
        w_next = w_inc;
        unique case (w_op)
            SEQ_JUMP: w_next = w_target;
            SEQ_BRGF: w_next = r_gfq ? w_target : w_inc;
            default:  w_next = w_inc;
        endcase
    end

    // Sequencer FSM: mpc, step watchdog, gf capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mpc   <= 6'd0;
            r_step  <= 8'd0;
            r_gfq   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mpc   <= entry;
                        r_step  <= 8'd0;
                        r_gfq   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_step <= r_step + 8'd1;
                    if (w_cmp) begin
                        r_gfq <= gf;
                    end
                    if (w_op == SEQ_END) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_trip) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_mpc <= w_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uaddr = r_mpc;
    assign busy  = w_run;
    assign done  = r_done;
    assign err   = r_err;

    // Controls are live copies of the microword, forced low outside RUN
    assign au_en = w_run & uword[3];
    assign ac    = w_run ? uword[7:4] : 4'h0;
    assign ld_a  = w_run & uword[2];
    assign ld_b  = w_run & uword[1];
    assign ld_r  = w_run & uword[0];

endmodule
